mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single 32-bit frame-memory port between the template reader, the window reader and the result writer in the per-set processing flow. Each requester is granted the port for a burst of up to BURST_LEN beats. Grants are awarded in round-robin order. Read return data is steered back to the requester that issued the read, using an in-order tag FIFO. The set sequencer sits above this block and only raises requests; this block resolves all port contention.

## Interface
Parameters:
- BURST_LEN, 16, maximum accepted beats per grant (2..256)
- MAX_OUTSTANDING, 4, maximum reads issued but not yet returned (power of two)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  3  per-requester request: bit 0 template, bit 1 window, bit 2 result write
- rd_wr_i  in  3  per-requester access type: 0 read, 1 write
- row_i  in  3x7  per-requester row
- col_i  in  3x7  per-requester col
- wdata_i  in  3x32  per-requester write data
- gnt_o  out  3  one-hot current owner, registered
- beat_ack_o  out  3  one-hot; the owner's beat was accepted this cycle
- rvalid_o  out  3  one-hot; read data is valid for that requester
- rdata_o  out  32  read data
- mem_req_o  out  1  beat request to memory
- mem_rd_wr_o  out  1  access type to memory
- mem_row_o, mem_col_o  out  7 each  address to memory
- mem_wdata_o  out  32  write data to memory
- mem_ready_i  in  1  memory accepts the beat this cycle
- mem_rvalid_i  in  1  memory read data valid; returns arrive in issue order
- mem_rdata_i  in  32  memory read data
- busy_o  out  1  the port is granted, or reads are outstanding
- err_o  out  1  sticky; set by a read return with no outstanding tag

## Operation
State machine states: IDLE, GRANT.

IDLE:
- If any req_i bit is set, pick a winner by round-robin, searching from last_owner+1.
- Load gnt_o with the winner, clear beat_cnt, and go to GRANT.

GRANT:
- mem_req_o = req_i[owner], gated low when rd_wr_i[owner]=0 and the tag FIFO holds MAX_OUTSTANDING entries.
- mem_rd_wr_o, mem_row_o, mem_col_o and mem_wdata_o are combinationally muxed from the owner. When no owner is granted they are 0.
- A beat is accepted when mem_req_o && mem_ready_i. On acceptance:
  - beat_ack_o[owner] pulses for that cycle;
  - beat_cnt increments;
  - for a read, the owner id is pushed into the tag FIFO.
- The grant ends when either:
  - the accepted beat brings beat_cnt to BURST_LEN, or
  - req_i[owner] is sampled low.
- When the grant ends: gnt_o ← 0, last_owner ← owner, go to IDLE.
- A requester may change rd_wr_i between beats within its own grant.

Read return:
- On mem_rvalid_i, pop the tag FIFO.
- rvalid_o[tag] = 1 and rdata_o = mem_rdata_i in the same cycle.
- Tag FIFO empty on mem_rvalid_i: rvalid_o stays 0, the data is dropped, and err_o sets.
- Push and pop in the same cycle: the count is unchanged, and the FIFO's full status is evaluated on the pre-update count.

Arithmetic and widths:
- beat_cnt is $clog2(BURST_LEN+1) bits.
- The tag count is $clog2(MAX_OUTSTANDING+1) bits.
- Pointers wrap modulo MAX_OUTSTANDING.

busy_o = (state==GRANT) || (tag count ≠ 0).

## Timing
- Reset values:
  - state IDLE; gnt_o, beat_ack_o, rvalid_o, mem_req_o all 0;
  - rdata_o follows mem_rdata_i; err_o 0;
  - last_owner = 2, so requester 0 wins first; tag FIFO empty.
- Request-to-grant latency: req_i sampled high in IDLE gives gnt_o high the next cycle. mem_req_o can assert in that same cycle.
- Grant release costs 1 cycle in IDLE before the next grant. The minimum gap between two owners' beats is 2 cycles.
- Read return is zero-latency pass-through; there is no output register.
- Reset asserted mid-burst: the grant and tag FIFO clear immediately. Memory must be reset together with this block. Stale returns after reset set err_o.

## Configuration
- ARB_WRITE_PRIORITY_EN defined: in IDLE, requester 2 (result write) wins whenever req_i[2]=1, regardless of the round-robin pointer. Among the other requesters, round-robin still applies. last_owner updates as normal.
- Not defined: pure round-robin across all three requesters.

## Structure
- Shared package mem_arb_pkg holds:
  - NUM_REQ = 3;
  - requester id enum: REQ_TEMPLATE = 0, REQ_WINDOW = 1, REQ_RESULT = 2;
  - state enum {IDLE, GRANT}.
- The sequencer and both handlers import the same package.
- One sub-module: mem_arb_tag_fifo, a MAX_OUTSTANDING-deep, 2-bit-wide synchronous FIFO. It has push, pop, full and empty outputs, and a count output.

## Test plan
- req_i=3'b011 held, mem_ready_i=1, BURST_LEN=16, reads, return latency 2 → 16 beats for requester 0, a 1-cycle gap, then 16 beats for requester 1. rvalid_o is 3'b001 for 16 returns, then 3'b010 for 16 returns; err_o stays 0.
- Single read requester, mem_rvalid_i held 0 → exactly 4 beats accepted, then mem_req_o=0 while full. One return re-enables exactly one beat.
- Owner drops req_i after 5 beats → gnt_o clears the next cycle, and the waiting requester is granted 1 cycle later.
- All three requesting with writes on requester 2, ARB_WRITE_PRIORITY_EN defined → the first grant is 3'b100. Without the macro, grants go 3'b001, 3'b010, 3'b100.
- mem_rvalid_i pulse with the FIFO empty → rvalid_o=0 and err_o=1 until reset. rst_n low mid-burst → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the frame-memory port arbiter: requester ids, FSM states
// and the round-robin helpers used by the arbiter and its tag FIFO.
package mem_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int REQ_IDW = 2;

    typedef enum logic [1:0] {
        REQ_TEMPLATE = 2'd0,
        REQ_WINDOW   = 2'd1,
        REQ_RESULT   = 2'd2
    } req_id_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Next requester id in round-robin order, wrapping 2 -> 0.
    function automatic logic [REQ_IDW-1:0] rr_next(input logic [REQ_IDW-1:0] id);
        logic [REQ_IDW-1:0] nxt;
        if (id == 2'd2) begin
            nxt = 2'd0;
        end else begin
            nxt = id + 2'd1;
        end
        return nxt;
    endfunction

    // First requesting id found when searching upward from last+1.
    function automatic logic [REQ_IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [REQ_IDW-1:0] last);
        logic [REQ_IDW-1:0] cand;
        logic [REQ_IDW-1:0] pick;
        logic               found;
        cand  = last;
        pick  = last;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_next(cand);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [REQ_IDW-1:0] id);
        logic [NUM_REQ-1:0] oh;
        case (id)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads issued to memory but not yet
// returned; pop data is the head entry, valid whenever empty_o is low.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [REQ_IDW-1:0] push_data_i,
    input  logic               pop_i,
    output logic [REQ_IDW-1:0] pop_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    logic [REQ_IDW-1:0] mem_q [DEPTH];
    logic [REQ_IDW-1:0] mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_s;
    logic               empty_s;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_s     = (count_q == CW'(DEPTH));
    assign empty_s    = (count_q == {CW{1'b0}});
    assign do_push_s  = push_i & ~full_s;
    assign do_pop_s   = pop_i & ~empty_s;
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer, count and storage next-state; full/empty use the pre-update count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter for the shared 32-bit frame-memory port, with
// in-order read-return steering. Define ARB_WRITE_PRIORITY_EN to let the
// result writer win every arbitration it requests.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       rd_wr_i,
    input  logic [NUM_REQ-1:0][6:0]  row_i,
    input  logic [NUM_REQ-1:0][6:0]  col_i,
    input  logic [NUM_REQ-1:0][31:0] wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       beat_ack_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     mem_req_o,
    output logic                     mem_rd_wr_o,
    output logic [6:0]               mem_row_o,
    output logic [6:0]               mem_col_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int TAG_CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    req_id_e            owner_q, owner_d;
    req_id_e            last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;

    req_id_e            win_s;
    logic               mem_req_s;
    logic               mem_rd_wr_s;
    logic [6:0]         mem_row_s;
    logic [6:0]         mem_col_s;
    logic [31:0]        mem_wdata_s;
    logic               beat_acc_s;
    logic [CNT_W-1:0]   beat_cnt_inc_s;
    logic               burst_done_s;

    logic               tag_push_s;
    logic               tag_pop_s;
    logic [REQ_IDW-1:0] tag_pop_data_s;
    logic               tag_full_s;
    logic               tag_empty_s;
    logic [TAG_CW-1:0]  tag_count_s;

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tag_push_s),
        .push_data_i (owner_q),
        .pop_i       (tag_pop_s),
        .pop_data_o  (tag_pop_data_s),
        .full_o      (tag_full_s),
        .empty_o     (tag_empty_s),
        .count_o     (tag_count_s)
    );

    // Arbitration winner for the next grant.
    always_comb begin
        win_s = REQ_TEMPLATE;
`ifdef ARB_WRITE_PRIORITY_EN
        if (req_i[REQ_RESULT]) begin
            win_s = REQ_RESULT;
        end else begin
            win_s = req_id_e'(rr_pick(req_i & 3'b011, last_owner_q));
        end
`else
        win_s = req_id_e'(rr_pick(req_i, last_owner_q));
`endif
    end

    // Owner-to-memory mux; reads are held back while the tag FIFO is full.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_rd_wr_s = 1'b0;
        mem_row_s   = 7'd0;
        mem_col_s   = 7'd0;
        mem_wdata_s = 32'd0;
        if (state_q == GRANT) begin
            mem_req_s   = req_i[owner_q] & ~(~rd_wr_i[owner_q] & tag_full_s);
            mem_rd_wr_s = rd_wr_i[owner_q];
            mem_row_s   = row_i[owner_q];
            mem_col_s   = col_i[owner_q];
            mem_wdata_s = wdata_i[owner_q];
        end else begin
            mem_req_s   = 1'b0;
        end
    end

    assign beat_acc_s     = mem_req_s & mem_ready_i;
    assign beat_cnt_inc_s = beat_cnt_q + CNT_W'(1);
    assign burst_done_s   = beat_acc_s & (beat_cnt_inc_s == CNT_W'(BURST_LEN));
    assign tag_push_s     = beat_acc_s & ~mem_rd_wr_s;
    assign tag_pop_s      = mem_rvalid_i;

    // Grant FSM next-state.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d    = GRANT;
                    gnt_d      = id_to_onehot(win_s);
                    owner_d    = win_s;
                    beat_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                if (beat_acc_s) begin
                    beat_cnt_d = beat_cnt_inc_s;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                if (burst_done_s || !req_i[owner_q]) begin
                    state_d      = IDLE;
                    gnt_d        = 3'b000;
                    last_owner_d = owner_q;
                end else begin
                    state_d      = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // A return with nothing outstanding is dropped and flagged permanently.
    always_comb begin
        err_d = err_q;
        if (mem_rvalid_i && tag_empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Arbiter state registers; requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 3'b000;
            owner_q      <= REQ_TEMPLATE;
            last_owner_q <= REQ_RESULT;
            beat_cnt_q   <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign beat_ack_o  = beat_acc_s ? gnt_q : 3'b000;
    assign rvalid_o    = (mem_rvalid_i && !tag_empty_s) ? id_to_onehot(tag_pop_data_s) : 3'b000;
    assign rdata_o     = mem_rdata_i;
    assign mem_req_o   = mem_req_s;
    assign mem_rd_wr_o = mem_rd_wr_s;
    assign mem_row_o   = mem_row_s;
    assign mem_col_o   = mem_col_s;
    assign mem_wdata_o = mem_wdata_s;
    assign busy_o      = (state_q == GRANT) || (tag_count_s != {TAG_CW{1'b0}});
    assign err_o       = err_q;

endmodule
